// File: rtl/fadd_pkg.sv
// Shared types and constants for the shared single-precision adder controller.
package fadd_pkg;

    localparam int FP_W = 32;

    localparam logic [FP_W-1:0] FP_ONE   = 32'h3F80_0000;
    localparam logic [FP_W-1:0] FP_TWO   = 32'h4000_0000;
    localparam logic [FP_W-1:0] FP_THREE = 32'h4040_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/adder.sv
// Combinational IEEE-754 single-precision adder, round to nearest even.
// Subnormals are handled; a NaN input yields a quiet NaN.
module adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] c
);

    logic [31:0] x, y;
    logic [7:0]  ex, ey, diff;
    logic [26:0] xa, ya, ys, nrm, tmp;
    logic [27:0] sum;
    logic [9:0]  e, sh;
    logic [5:0]  lz;
    logic [24:0] rnd;

    always_comb begin
        // x carries the larger magnitude, so it also supplies the result sign
        x    = (b[30:0] > a[30:0]) ? b : a;
        y    = (b[30:0] > a[30:0]) ? a : b;
        ex   = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey   = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        diff = ex - ey;
        xa   = {(x[30:23] != 8'd0), x[22:0], 3'b000};
        ya   = {(y[30:23] != 8'd0), y[22:0], 3'b000};
        if (diff > 8'd26) begin
            ys = {26'd0, |ya};
        end else begin
            ys    = ya >> diff;
            ys[0] = ys[0] | ((ya & ((27'd1 << diff) - 27'd1)) != 27'd0);
        end
        sum = (x[31] ^ y[31]) ? ({1'b0, xa} - {1'b0, ys}) : ({1'b0, xa} + {1'b0, ys});
        e   = {2'b00, ex};
        if (sum[27]) begin
            nrm = sum[27:1] | {26'd0, sum[0]};
            e   = e + 10'd1;
        end else begin
            nrm = sum[26:0];
        end
        lz  = 6'd0;
        tmp = nrm;
        for (int i = 0; i < 27; i++) begin
            if (!tmp[26]) begin
                tmp = tmp << 1;
                lz  = lz + 6'd1;
            end
        end
        sh  = ({4'd0, lz} >= e) ? e - 10'd1 : {4'd0, lz};
        nrm = nrm << sh;
        e   = e - sh;
        rnd = {1'b0, nrm[26:3]} + {24'd0, nrm[2] & (nrm[1] | nrm[0] | nrm[3])};
        if (rnd[24]) begin
            rnd = rnd >> 1;
            e   = e + 10'd1;
        end
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] != 23'd0)
                c = x | 32'h0040_0000;
            else if (y[30:23] == 8'hFF && x[31] != y[31])
                c = 32'h7FC0_0000;
            else
                c = x;
        end else if (sum == 28'd0) begin
            c = {x[31] & y[31], 31'd0};
        end else if (e >= 10'd255) begin
            c = {x[31], 8'hFF, 23'd0};
        end else begin
            c = {x[31], rnd[23] ? e[7:0] : 8'd0, rnd[22:0]};
        end
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    output logic               any,
    output logic [IDW-1:0]     pick
);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        any   = |req;
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

endmodule

// File: rtl/fadd_share_ctrl.sv
// Round-robin sharing of one combinational FP adder among NUM_REQ requesters.
// Optional macro FADD_SHARE_SUB_EN adds req_sub, turning a request into A-B.
module fadd_share_ctrl
    import fadd_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                    sysclk,
    input  logic                    cpu_resetn,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*FP_W-1:0] req_a,
    input  logic [NUM_REQ*FP_W-1:0] req_b,
`ifdef FADD_SHARE_SUB_EN
    input  logic [NUM_REQ-1:0]      req_sub,
`endif
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [FP_W-1:0]         rsp_data,
    output logic                    busy,
    output logic [IDW-1:0]          grant_id
);

    state_t                         state;
    logic [IDW-1:0]                 rr_ptr, owner, pick;
    logic                           any;
    logic [FP_W-1:0]                a_r, b_r, sum_c, a_sel, b_sel;
    logic [NUM_REQ-1:0][FP_W-1:0]   a_vec, b_vec;

    assign a_vec = req_a;
    assign b_vec = req_b;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .any    (any),
        .pick   (pick)
    );

    adder u_adder (
        .a (a_r),
        .b (b_r),
        .c (sum_c)
    );

    always_comb begin
        a_sel = a_vec[pick];
        b_sel = b_vec[pick];
`ifdef FADD_SHARE_SUB_EN
        b_sel[FP_W-1] = b_sel[FP_W-1] ^ req_sub[pick];
`endif
        req_ready = '0;
        if (cpu_resetn && state == IDLE && any)
            req_ready[pick] = 1'b1;
    end

    always_ff @(posedge sysclk) begin
        if (!cpu_resetn) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            grant_id  <= '0;
            a_r       <= '0;
            b_r       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        a_r      <= a_sel;
                        b_r      <= b_sel;
                        owner    <= pick;
                        grant_id <= pick;
                        rr_ptr   <= (int'(pick) == NUM_REQ - 1) ? '0 : pick + IDW'(1);
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    rsp_data  <= sum_c;
                    rsp_valid <= NUM_REQ'(1) << owner;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fadd_share_ctrl.sv
// Bench for fadd_share_ctrl: directed scenarios plus randomized transactions
// predicted by an integer-arithmetic reference model of arbitration and sums.
module tb_fadd_share_ctrl;
    import fadd_pkg::*;

    localparam int NR = 4;

    logic                 sysclk = 1'b0;
    logic                 cpu_resetn;
    logic [NR-1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NR-1:0][31:0]  req_a, req_b;
`ifdef FADD_SHARE_SUB_EN
    logic [NR-1:0]        req_sub;
`endif
    logic [31:0]          rsp_data;
    logic                 busy;
    logic [1:0]           grant_id;

    int checks  = 0;
    int passed  = 0;
    int exp_ptr = 0;

    fadd_share_ctrl #(.NUM_REQ(NR)) dut (
        .sysclk     (sysclk),
        .cpu_resetn (cpu_resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
`ifdef FADD_SHARE_SUB_EN
        .req_sub    (req_sub),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    // Exact IEEE single encoding of a small integer.
    function automatic logic [31:0] int_to_fp(input int v);
        int          m, p;
        logic [31:0] r;
        if (v == 0) return 32'h0;
        m = (v < 0) ? -v : v;
        p = 0;
        for (int k = 0; k < 31; k++)
            if (m >= (1 << k)) p = k;
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + p);
        r[22:0]  = 23'((m << (23 - p)) & 32'h007F_FFFF);
        return r;
    endfunction

    function automatic int model_pick(input logic [NR-1:0] mask, input int ptr);
        int id;
        for (int k = 0; k < NR; k++) begin
            id = (ptr + k) % NR;
            if (((mask >> id) & 1) != 0) return id;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic do_reset();
        cpu_resetn = 1'b0;
        req_valid  = '0;
        rsp_ready  = '0;
        req_a      = '0;
        req_b      = '0;
`ifdef FADD_SHARE_SUB_EN
        req_sub    = '0;
`endif
        tick();
        tick();
        cpu_resetn = 1'b1;
        exp_ptr    = 0;
    endtask

    task automatic test_reset();
        cpu_resetn = 1'b0;
        req_valid  = '1;
        rsp_ready  = '0;
        req_a      = '0;
        req_b      = '0;
`ifdef FADD_SHARE_SUB_EN
        req_sub    = '0;
`endif
        tick();
        tick();
        checks++; if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); else passed++;
        checks++; if (rsp_data !== 32'h0) $display("FAIL reset_rsp_data: got %h want 00000000", rsp_data); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (grant_id !== 2'd0) $display("FAIL reset_grant_id: got %0d want 0", grant_id); else passed++;
        checks++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", req_ready); else passed++;
        req_valid  = '0;
        cpu_resetn = 1'b1;
        exp_ptr    = 0;
    endtask

    task automatic test_single_add();
        do_reset();
        req_a[0]  = FP_ONE;
        req_b[0]  = FP_TWO;
        rsp_ready = 4'b0001;
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b want 0001", req_ready); else passed++;
        tick();
        req_valid = '0;
        checks++; if ({busy, grant_id, rsp_valid} !== {1'b1, 2'd0, 4'b0000})
            $display("FAIL single_calc: got busy=%b id=%0d rv=%b want busy=1 id=0 rv=0000", busy, grant_id, rsp_valid); else passed++;
        tick();
        checks++; if (rsp_valid !== 4'b0001 || rsp_data !== FP_THREE || busy !== 1'b1)
            $display("FAIL single_rsp: got rv=%b data=%h busy=%b want rv=0001 data=%h busy=1", rsp_valid, rsp_data, busy, FP_THREE); else passed++;
        tick();
        checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0)
            $display("FAIL single_done: got rv=%b busy=%b want rv=0000 busy=0", rsp_valid, busy); else passed++;
        rsp_ready = '0;
    endtask

    task automatic test_round_robin();
        int            g;
        logic [NR-1:0] oh;
        do_reset();
        for (int i = 0; i < NR; i++) begin
            req_a[i] = int_to_fp(i + 1);
            req_b[i] = int_to_fp(10 * (i + 1));
        end
        rsp_ready = '1;
        req_valid = '1;
        #1;
        for (int t = 0; t < 5; t++) begin
            g  = model_pick(req_valid, exp_ptr);
            oh = NR'(1) << g;
            checks++; if (req_ready !== oh) $display("FAIL rr_ready[%0d]: got %b want %b", t, req_ready, oh); else passed++;
            tick();
            checks++; if (grant_id !== 2'(g)) $display("FAIL rr_grant[%0d]: got %0d want %0d", t, grant_id, g); else passed++;
            tick();
            checks++; if (rsp_valid !== oh || rsp_data !== int_to_fp(11 * (g + 1)))
                $display("FAIL rr_rsp[%0d]: got rv=%b data=%h want rv=%b data=%h", t, rsp_valid, rsp_data, oh, int_to_fp(11 * (g + 1))); else passed++;
            tick();
            checks++; if (busy !== 1'b0) $display("FAIL rr_idle[%0d]: got busy=%b want 0", t, busy); else passed++;
            exp_ptr = (g + 1) % NR;
        end
        req_valid = '0;
        rsp_ready = '0;
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset();
        req_a[1]  = int_to_fp(7);
        req_b[1]  = int_to_fp(-2);
        req_a[2]  = int_to_fp(100);
        req_b[2]  = int_to_fp(23);
        req_valid = 4'b0110;
        rsp_ready = 4'b0000;
        #1;
        checks++; if (req_ready !== 4'b0010) $display("FAIL bp_ready: got %b want 0010", req_ready); else passed++;
        tick();
        req_valid = 4'b0100;
        checks++; if (grant_id !== 2'd1) $display("FAIL bp_grant1: got %0d want 1", grant_id); else passed++;
        tick();
        checks++; if (rsp_valid !== 4'b0010 || rsp_data !== int_to_fp(5))
            $display("FAIL bp_rsp: got rv=%b data=%h want rv=0010 data=%h", rsp_valid, rsp_data, int_to_fp(5)); else passed++;
        bad       = 0;
        rsp_ready = 4'b1101;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (rsp_valid !== 4'b0010 || rsp_data !== int_to_fp(5) || req_ready !== 4'b0000 || busy !== 1'b1)
                bad++;
        end
        checks++; if (bad != 0) $display("FAIL bp_stall: got %0d unstable cycles want 0", bad); else passed++;
        rsp_ready = 4'b0010;
        tick();
        rsp_ready = 4'b0000;
        checks++; if (rsp_valid !== 4'b0000 || req_ready !== 4'b0100)
            $display("FAIL bp_release: got rv=%b ready=%b want rv=0000 ready=0100", rsp_valid, req_ready); else passed++;
        tick();
        req_valid = '0;
        checks++; if (grant_id !== 2'd2 || busy !== 1'b1)
            $display("FAIL bp_grant2: got id=%0d busy=%b want id=2 busy=1", grant_id, busy); else passed++;
        tick();
        checks++; if (rsp_valid !== 4'b0100 || rsp_data !== int_to_fp(123))
            $display("FAIL bp_rsp2: got rv=%b data=%h want rv=0100 data=%h", rsp_valid, rsp_data, int_to_fp(123)); else passed++;
        rsp_ready = 4'b0100;
        tick();
        rsp_ready = '0;
    endtask

    task automatic test_pointer_fairness();
        do_reset();
        req_a[1]  = int_to_fp(1);
        req_b[1]  = int_to_fp(1);
        req_valid = 4'b0010;
        rsp_ready = '1;
        tick();
        req_valid = '0;
        tick();
        tick();
        req_a[0]  = int_to_fp(4);
        req_b[0]  = int_to_fp(4);
        req_valid = 4'b0011;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("FAIL fair_ready0: got %b want 0001", req_ready); else passed++;
        tick();
        checks++; if (grant_id !== 2'd0) $display("FAIL fair_grant0: got %0d want 0", grant_id); else passed++;
        tick();
        checks++; if (rsp_valid !== 4'b0001 || rsp_data !== int_to_fp(8))
            $display("FAIL fair_rsp0: got rv=%b data=%h want rv=0001 data=%h", rsp_valid, rsp_data, int_to_fp(8)); else passed++;
        tick();
        checks++; if (req_ready !== 4'b0010) $display("FAIL fair_ready1: got %b want 0010", req_ready); else passed++;
        tick();
        checks++; if (grant_id !== 2'd1) $display("FAIL fair_grant1: got %0d want 1", grant_id); else passed++;
        tick();
        tick();
        req_valid = '0;
        rsp_ready = '0;
    endtask

    task automatic test_reset_mid_op();
        int seen;
        do_reset();
        req_a[2]  = int_to_fp(9);
        req_b[2]  = int_to_fp(9);
        req_valid = 4'b0100;
        rsp_ready = '1;
        tick();
        req_valid = '0;
        tick();
        tick();
        req_a[1]  = int_to_fp(3);
        req_b[1]  = int_to_fp(3);
        req_valid = 4'b0010;
        rsp_ready = '0;
        tick();
        checks++; if (grant_id !== 2'd1 || busy !== 1'b1)
            $display("FAIL mid_pre: got id=%0d busy=%b want id=1 busy=1", grant_id, busy); else passed++;
        cpu_resetn = 1'b0;
        req_valid  = '0;
        tick();
        checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0)
            $display("FAIL mid_state: got rv=%b busy=%b want rv=0000 busy=0", rsp_valid, busy); else passed++;
        checks++; if (grant_id !== 2'd0 || rsp_data !== 32'h0)
            $display("FAIL mid_regs: got id=%0d data=%h want id=0 data=00000000", grant_id, rsp_data); else passed++;
        cpu_resetn = 1'b1;
        rsp_ready  = '1;
        seen       = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (rsp_valid !== 4'b0000) seen++;
        end
        checks++; if (seen != 0) $display("FAIL mid_no_rsp: got %0d response cycles want 0", seen); else passed++;
        req_valid = '1;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("FAIL mid_ptr: got %b want 0001", req_ready); else passed++;
        req_valid = '0;
        rsp_ready = '0;
        exp_ptr   = 0;
    endtask

    task automatic test_sub();
        logic [31:0] want;
        do_reset();
        req_a[0]  = FP_THREE;
        req_b[0]  = FP_ONE;
`ifdef FADD_SHARE_SUB_EN
        req_sub   = 4'b0001;
        want      = FP_TWO;
`else
        want      = 32'h4080_0000;
`endif
        req_valid = 4'b0001;
        rsp_ready = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        checks++; if (rsp_valid !== 4'b0001 || rsp_data !== want)
            $display("FAIL sub_result: got rv=%b data=%h want rv=0001 data=%h", rsp_valid, rsp_data, want); else passed++;
        tick();
        rsp_ready = '0;
`ifdef FADD_SHARE_SUB_EN
        req_sub   = '0;
`endif
    endtask

    task automatic test_random();
        int            av [NR];
        int            bv [NR];
        bit            sv [NR];
        logic [NR-1:0] mask, oh;
        logic [31:0]   want;
        int            g, d, bad;
        do_reset();
        for (int t = 0; t < 40; t++) begin
            mask = NR'($urandom_range(15, 1));
            for (int i = 0; i < NR; i++) begin
                av[i]    = int'($urandom_range(4000)) - 2000;
                bv[i]    = int'($urandom_range(4000)) - 2000;
                sv[i]    = 1'b0;
                req_a[i] = int_to_fp(av[i]);
                req_b[i] = int_to_fp(bv[i]);
`ifdef FADD_SHARE_SUB_EN
                sv[i]      = 1'($urandom_range(1));
                req_sub[i] = sv[i];
`endif
            end
            req_valid = mask;
            rsp_ready = '0;
            #1;
            g    = model_pick(mask, exp_ptr);
            oh   = NR'(1) << g;
            want = int_to_fp(sv[g] ? av[g] - bv[g] : av[g] + bv[g]);
            checks++; if (req_ready !== oh) $display("FAIL rnd_ready[%0d]: got %b want %b", t, req_ready, oh); else passed++;
            tick();
            req_valid = '0;
            req_a[g]  = $urandom;
            req_b[g]  = $urandom;
            checks++; if ({busy, grant_id, req_ready} !== {1'b1, 2'(g), 4'b0000})
                $display("FAIL rnd_grant[%0d]: got busy=%b id=%0d ready=%b want busy=1 id=%0d ready=0000", t, busy, grant_id, req_ready, g); else passed++;
            tick();
            checks++; if (rsp_valid !== oh || rsp_data !== want)
                $display("FAIL rnd_rsp[%0d]: got rv=%b data=%h want rv=%b data=%h", t, rsp_valid, rsp_data, oh, want); else passed++;
            d   = int'($urandom_range(3));
            bad = 0;
            for (int k = 0; k < d; k++) begin
                rsp_ready = NR'($urandom) & ~oh;
                req_valid = NR'($urandom);
                tick();
                if (rsp_valid !== oh || rsp_data !== want || req_ready !== 4'b0000) bad++;
            end
            checks++; if (bad != 0) $display("FAIL rnd_stall[%0d]: got %0d unstable cycles want 0", t, bad); else passed++;
            rsp_ready = oh;
            req_valid = '0;
            tick();
            checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0)
                $display("FAIL rnd_done[%0d]: got rv=%b busy=%b want rv=0000 busy=0", t, rsp_valid, busy); else passed++;
            rsp_ready = '0;
            exp_ptr   = (g + 1) % NR;
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_round_robin();
        test_backpressure();
        test_pointer_fairness();
        test_reset_mid_op();
        test_sub();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
